// File: rtl/des_key_schedule_if.sv
// rtl/des_key_schedule_if.sv - key request / packed round-key result bundle for des_key_schedule
interface des_key_schedule_if;
  logic         start;
  logic [63:0]  key;
  logic         decrypt;
  logic         busy;
  logic         done;
  logic [767:0] round_keys;

  modport master (output start, key, decrypt, input busy, done, round_keys);
  modport slave  (input start, key, decrypt, output busy, done, round_keys);
endinterface

// File: rtl/des_key_schedule.sv
// rtl/des_key_schedule.sv - sequential DES key schedule: PC-1, 16 C/D rotations, PC-2, packed K1..K16
module des_key_schedule #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  des_key_schedule_if.slave ks
);
  localparam int LAST_CNT = 16 / ROUNDS_PER_CYCLE - 1;

  // Tables use DES bit numbering: bit 1 is the MSB of the source vector.
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Bit r set means round r+1 rotates by one; all other rounds rotate by two.
  localparam logic [15:0] SINGLE_SHIFT = 16'h8103;

  typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

  state_t       state, state_nxt;
  logic [27:0]  c_q, d_q, c_nxt, d_nxt;
  logic         dec_q;
  logic [3:0]   cnt_q;
  logic [767:0] keys_q;
  logic [47:0]  k_ch    [ROUNDS_PER_CYCLE];
  logic [3:0]   slot_ch [ROUNDS_PER_CYCLE];

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[6'(55 - i)] = k[6'(64 - PC1[i])];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[6'(47 - i)] = cd[6'(56 - PC2[i])];
    return r;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] v, input logic two);
    return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
  endfunction

  always_comb begin
    logic [27:0] c_t, d_t;
    logic [3:0]  rn;
    c_t = c_q;
    d_t = d_q;
    rn  = '0;
    for (int i = 0; i < ROUNDS_PER_CYCLE; i++) begin
      rn         = 4'(int'(cnt_q) * ROUNDS_PER_CYCLE + i);
      c_t        = rotl(c_t, ~SINGLE_SHIFT[rn]);
      d_t        = rotl(d_t, ~SINGLE_SHIFT[rn]);
      k_ch[i]    = pc2({c_t, d_t});
      slot_ch[i] = dec_q ? 4'd15 - rn : rn;
    end
    c_nxt = c_t;
    d_nxt = d_t;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ks.busy   = 1'b0;
    ks.done   = 1'b0;
    case (state)
      IDLE: if (ks.start) state_nxt = GEN;
      GEN: begin
        ks.busy = 1'b1;
        if (cnt_q == 4'(LAST_CNT)) state_nxt = DONE;
      end
      DONE: begin
        ks.busy   = 1'b1;
        ks.done   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The 16 rotations total 28 bits, so C/D end up back at PC-1(key) without a reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_q    <= '0;
      d_q    <= '0;
      dec_q  <= 1'b0;
      cnt_q  <= '0;
      keys_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ks.start) begin
            {c_q, d_q} <= pc1(ks.key);
            dec_q      <= ks.decrypt;
            cnt_q      <= '0;
          end
        end
        GEN: begin
          c_q   <= c_nxt;
          d_q   <= d_nxt;
          cnt_q <= (cnt_q == 4'(LAST_CNT)) ? 4'd0 : cnt_q + 4'd1;
          for (int i = 0; i < ROUNDS_PER_CYCLE; i++)
            keys_q[10'(767 - 48 * int'(slot_ch[i])) -: 48] <= k_ch[i];
        end
        default: ;
      endcase
    end
  end

  assign ks.round_keys = keys_q;

endmodule
